// File: rtl/sw_frame_handler_pkg.sv
// Shared definitions for the per-switch frame handler: frame field positions,
// operation encodings and the execution FSM state type.
package sw_frame_handler_pkg;

  localparam int OP_ID_LSB    = 0;
  localparam int OP_ID_MSB    = 7;
  localparam int DATA_LSB     = 8;
  localparam int DATA_MSB     = 15;
  localparam int WR_RD_BIT    = 16;
  localparam int REG_ADDR_LSB = 17;
  localparam int REG_ADDR_MSB = 21;

  localparam logic WR_OP = 1'b1;
  localparam logic RD_OP = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage : sw_frame_handler_pkg

// File: rtl/sw_frame_fifo.sv
// Small synchronous frame FIFO with registered read data. Pushes while full are
// dropped here; the parent tracks the sticky overflow indication.
module sw_frame_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = rd_data_q;

  // A full FIFO refuses the push even if a pop frees a slot in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    count_d   = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_data_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + AW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
      count_q   <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
      count_q   <= count_d;
    end
  end

endmodule : sw_frame_fifo

// File: rtl/sw_frame_handler.sv
// Per-switch consumer: queues request frames, executes each against a local
// register bank and returns one response per frame over valid/ready.
module sw_frame_handler
  import sw_frame_handler_pkg::*;
#(
  parameter int FRAME_WIDTH = 32,
  parameter int W_WIDTH     = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int REG_NUM     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_wr_en,
  input  logic [FRAME_WIDTH-1:0] frame_in,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   overflow,
  output logic                   busy,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [7:0]             resp_op_id,
  output logic [W_WIDTH-1:0]     resp_data,
  output logic                   resp_wr
);

  localparam int RAW = $clog2(REG_NUM);

  state_e                 state_q, state_d;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;
  logic [W_WIDTH-1:0]     regs_q [REG_NUM];
  logic [W_WIDTH-1:0]     regs_d [REG_NUM];
  logic                   resp_valid_q, resp_valid_d;
  logic [7:0]             resp_op_id_q, resp_op_id_d;
  logic [W_WIDTH-1:0]     resp_data_q, resp_data_d;
  logic                   resp_wr_q, resp_wr_d;
  logic                   overflow_q, overflow_d;

  logic [FRAME_WIDTH-1:0] fifo_rd_data;
  logic                   fifo_pop;
  logic [7:0]             frame_op_id;
  logic [W_WIDTH-1:0]     frame_data;
  logic                   frame_is_wr;
  logic [RAW-1:0]         frame_addr;
  logic                   frame_unused;

  sw_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_wr_en),
    .pop     (fifo_pop),
    .wr_data (frame_in),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  assign frame_op_id  = frame_q[OP_ID_MSB:OP_ID_LSB];
  assign frame_data   = frame_q[DATA_MSB:DATA_LSB];
  assign frame_is_wr  = (frame_q[WR_RD_BIT] == WR_OP);
  assign frame_addr   = frame_q[REG_ADDR_MSB:REG_ADDR_LSB];
  assign frame_unused = ^frame_q[FRAME_WIDTH-1:REG_ADDR_MSB+1];

  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_op_id = resp_op_id_q;
  assign resp_data  = resp_data_q;
  assign resp_wr    = resp_wr_q;

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    regs_d       = regs_q;
    resp_valid_d = resp_valid_q;
    resp_op_id_d = resp_op_id_q;
    resp_data_d  = resp_data_q;
    resp_wr_d    = resp_wr_q;
    overflow_d   = overflow_q || (fifo_wr_en && fifo_full);
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        frame_d = fifo_rd_data;
        state_d = EXEC;
      end
      EXEC: begin
        if (frame_is_wr) begin
          regs_d[frame_addr] = frame_data;
          resp_data_d        = frame_data;
          resp_wr_d          = WR_OP;
        end else begin
          resp_data_d = regs_q[frame_addr];
          resp_wr_d   = RD_OP;
        end
        resp_op_id_d = frame_op_id;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        // Response fields stay frozen until the consumer takes them.
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      regs_q       <= '{default: '0};
      resp_valid_q <= 1'b0;
      resp_op_id_q <= '0;
      resp_data_q  <= '0;
      resp_wr_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      regs_q       <= regs_d;
      resp_valid_q <= resp_valid_d;
      resp_op_id_q <= resp_op_id_d;
      resp_data_q  <= resp_data_d;
      resp_wr_q    <= resp_wr_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule : sw_frame_handler

// File: tb/tb_sw_frame_handler.sv
// Self-checking bench for sw_frame_handler: a frame-level model fills a
// response scoreboard as frames are pushed; a monitor drains it on handshakes.
module tb_sw_frame_handler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_wr_en;
  logic [31:0] frame_in;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;
  logic        busy;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_op_id;
  logic [7:0]  resp_data;
  logic        resp_wr;

  int errors = 0;
  int checks = 0;

  logic [16:0] exp_q [$];
  logic [7:0]  model_regs [32];
  logic        hold_prev = 1'b0;
  logic [16:0] hold_fields = '0;

  sw_frame_handler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_wr_en (fifo_wr_en),
    .frame_in   (frame_in),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_op_id (resp_op_id),
    .resp_data  (resp_data),
    .resp_wr    (resp_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_frame(input logic [4:0] addr, input logic wr,
                                           input logic [7:0] data, input logic [7:0] op);
    return {10'd0, addr, wr, data, op};
  endfunction

  // Monitor: scoreboard compare on every handshake, stability check while stalled.
  always @(negedge clk) begin
    logic [16:0] got;
    logic [16:0] exp;
    got = {resp_op_id, resp_data, resp_wr};
    if (rst_n) begin
      if (hold_prev) begin
        checks++;
        if (!resp_valid || got !== hold_fields) begin
          errors++;
          $display("[TB] FAIL stall_hold: got valid=%0b fields=%h, required valid=1 fields=%h",
                   resp_valid, got, hold_fields);
        end
      end
      if (resp_valid && resp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_resp: got op=%h data=%h wr=%0b, required no response",
                   resp_op_id, resp_data, resp_wr);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("[TB] FAIL resp: got op=%h data=%h wr=%0b, required op=%h data=%h wr=%0b",
                     got[16:9], got[8:1], got[0], exp[16:9], exp[8:1], exp[0]);
          end
        end
      end
      hold_prev   = resp_valid && !resp_ready;
      hold_fields = got;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic push_frame(input logic [31:0] f, input bit accept);
    logic [4:0] addr;
    @(posedge clk);
    #1;
    fifo_wr_en = 1'b1;
    frame_in   = f;
    if (accept) begin
      addr = f[21:17];
      if (f[16]) begin
        model_regs[addr] = f[15:8];
        exp_q.push_back({f[7:0], f[15:8], 1'b1});
      end else begin
        exp_q.push_back({f[7:0], model_regs[addr], 1'b0});
      end
    end
  endtask

  task automatic end_push();
    @(posedge clk);
    #1;
    fifo_wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_%s: got %0d responses outstanding, required 0", name, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    logic [20:0] got;
    got = {resp_valid, busy, fifo_empty, fifo_full, overflow, resp_wr, resp_op_id, resp_data};
    checks++;
    if (got !== {5'b00100, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("[TB] FAIL %s: got valid/busy/empty/full/ovf/wr/op/data=%h, required %h",
               name, got, {5'b00100, 1'b0, 8'h00, 8'h00});
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < 32; i++) model_regs[i] = 8'h00;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    fifo_wr_en = 1'b0;
    frame_in   = '0;
    resp_ready = 1'b0;
    clear_model();
    #23;
    check_reset_outputs("reset_asserted");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("reset_released");
  endtask

  task automatic test_write_read();
    resp_ready = 1'b1;
    push_frame(mk_frame(5'd5, 1'b1, 8'hA5, 8'h11), 1'b1);
    end_push();
    @(negedge clk);
    checks++;
    if (fifo_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_after_push: got %0b, required 0", fifo_empty);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_fetch: got %0b, required 1", busy);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_early: got resp_valid=%0b, required 0", resp_valid);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_n4: got resp_valid=%0b, required 1", resp_valid);
    end
    wait_drain(20, "write");
    push_frame(mk_frame(5'd5, 1'b0, 8'h00, 8'h12), 1'b1);
    push_frame(mk_frame(5'd6, 1'b0, 8'hFF, 8'h13), 1'b1);
    end_push();
    wait_drain(40, "read");
  endtask

  task automatic test_push_pop_same_cycle();
    resp_ready = 1'b0;
    push_frame(mk_frame(5'd3, 1'b1, 8'h5A, 8'h21), 1'b1);
    end_push();
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stalled_valid: got %0b, required 1", resp_valid);
    end
    push_frame(mk_frame(5'd3, 1'b0, 8'h00, 8'h22), 1'b1);
    push_frame(mk_frame(5'd4, 1'b1, 8'h99, 8'h23), 1'b1);
    end_push();
    repeat (3) @(posedge clk);
    #1;
    resp_ready = 1'b1;
    push_frame(mk_frame(5'd4, 1'b0, 8'h00, 8'h24), 1'b1);
    resp_ready = 1'b0;
    push_frame(mk_frame(5'd3, 1'b0, 8'h00, 8'h25), 1'b1);
    checks++;
    if (fifo_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pushpop_count2: got full=%0b, required 0", fifo_full);
    end
    push_frame(mk_frame(5'd6, 1'b1, 8'h66, 8'h26), 1'b1);
    checks++;
    if (fifo_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pushpop_count3: got full=%0b, required 0", fifo_full);
    end
    end_push();
    checks++;
    if ({fifo_full, overflow} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL pushpop_count4: got full/ovf=%b, required 10", {fifo_full, overflow});
    end
    resp_ready = 1'b1;
    wait_drain(60, "pushpop");
  endtask

  task automatic test_overflow();
    resp_ready = 1'b0;
    push_frame(mk_frame(5'd8, 1'b1, 8'h31, 8'h31), 1'b1);
    push_frame(mk_frame(5'd8, 1'b0, 8'h00, 8'h32), 1'b1);
    push_frame(mk_frame(5'd9, 1'b1, 8'h33, 8'h33), 1'b1);
    push_frame(mk_frame(5'd9, 1'b0, 8'h00, 8'h34), 1'b1);
    push_frame(mk_frame(5'd8, 1'b1, 8'h35, 8'h35), 1'b1);
    push_frame(mk_frame(5'd8, 1'b1, 8'hEE, 8'h36), 1'b0);
    checks++;
    if ({fifo_full, overflow} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL full_before_drop: got full/ovf=%b, required 10", {fifo_full, overflow});
    end
    end_push();
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_set: got %0b, required 1", overflow);
    end
    resp_ready = 1'b1;
    wait_drain(80, "overflow");
    checks++;
    if ({overflow, fifo_empty} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL overflow_sticky: got ovf/empty=%b, required 11", {overflow, fifo_empty});
    end
  endtask

  task automatic test_random_ready();
    int n = 0;
    resp_ready = 1'b0;
    push_frame(mk_frame(5'd10, 1'b1, 8'h3C, 8'h40), 1'b1);
    push_frame(mk_frame(5'd10, 1'b0, 8'h00, 8'h41), 1'b1);
    push_frame(mk_frame(5'd10, 1'b1, 8'hC3, 8'h42), 1'b1);
    push_frame(mk_frame(5'd10, 1'b0, 8'h00, 8'h43), 1'b1);
    end_push();
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      resp_ready = 1'($urandom_range(0, 1));
      n++;
    end
    resp_ready = 1'b1;
    wait_drain(20, "random");
  endtask

  task automatic test_reset_mid_op();
    resp_ready = 1'b1;
    push_frame(mk_frame(5'd5, 1'b1, 8'h77, 8'h50), 1'b1);
    end_push();
    wait_drain(20, "preload");
    push_frame(mk_frame(5'd5, 1'b1, 8'h81, 8'h51), 1'b1);
    push_frame(mk_frame(5'd5, 1'b1, 8'h82, 8'h52), 1'b1);
    push_frame(mk_frame(5'd5, 1'b1, 8'h83, 8'h53), 1'b1);
    push_frame(mk_frame(5'd5, 1'b1, 8'h84, 8'h54), 1'b1);
    checks++;
    if ({busy, fifo_empty, resp_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL exec_before_reset: got busy/empty/valid=%b, required 100",
               {busy, fifo_empty, resp_valid});
    end
    #2;
    rst_n      = 1'b0;
    fifo_wr_en = 1'b0;
    clear_model();
    #1;
    check_reset_outputs("reset_mid_op");
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(mk_frame(5'd5, 1'b0, 8'h00, 8'h60), 1'b1);
    end_push();
    wait_drain(20, "after_reset");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_push_pop_same_cycle();
    test_overflow();
    test_random_ready();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sw_frame_handler
